muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the RV32 M-extension operations, paired with the single-cycle integer ALU in the execute stage.
- Accepts one MUL/DIV/REM operation at a time through a valid/ready handshake.
- Computes the result with an internal iterative shift-add / restoring-subtract datapath, then returns it with a one-cycle done pulse.
- The hazard unit stalls the pipeline while busy_o is high.

---
 rtl/muldiv_seq.sv | 161 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32 M-extension unit: 32-step shift-add multiply / restoring divide,
// one request at a time, with an optional early-out for div-by-zero and signed overflow.
module muldiv_seq #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  // Handshake: a request is taken on a rising edge where ready_o && valid_i && !flush_i;
  // done_o pulses for one cycle with result_o valid and there is no back-pressure on it.

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

  state_e            state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div_zero_q, div_zero_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept;
  logic              a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              b_zero, ovf, early;
  logic [XLEN-1:0]   early_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign accept = (state_q == IDLE) && valid_i && !flush_i;

  // Operand preparation from the live request inputs
  always_comb begin
    a_signed  = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    b_signed  = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    sign_a    = a_signed && src_a_i[XLEN-1];
    sign_b    = b_signed && src_b_i[XLEN-1];
    mag_a     = sign_a ? -src_a_i : src_a_i;
    mag_b     = sign_b ? -src_b_i : src_b_i;
    b_zero    = (src_b_i == '0);
    ovf       = op_i[2] && !op_i[0] && (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_i == '1);
    early     = (EARLY_OUT != 1'b0) && op_i[2] && (b_zero || ovf);
    early_res = b_zero ? (op_i[1] ? src_a_i : '1)
                       : (op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  end

  // One iteration step; acc holds {hi, lo} for multiply and {remainder, quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, opb_q};
    div_ge    = !div_diff[XLEN];
    div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
  end

  // Sign fix-up and result select; divide-by-zero quotient is all ones regardless of sign
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = div_zero_q ? '1 : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo;
      default:                fix_res = rem;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    op_d       = op_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    result_d   = result_q;
    if (accept) begin
      op_d       = op_i;
      count_d    = 5'd0;
      neg_d      = sign_a ^ sign_b;
      neg_rem_d  = sign_a;
      div_zero_d = b_zero;
      if (op_i[2]) begin
        acc_d = {{XLEN{1'b0}}, mag_a};
        opb_d = mag_b;
      end else begin
        acc_d = {{XLEN{1'b0}}, mag_b};
        opb_d = mag_a;
      end
      if (early) result_d = early_res;
    end else if (state_q == CALC) begin
      acc_d   = op_q[2] ? div_next : mul_next;
      count_d = count_q + 5'd1;
    end else if (state_q == FIXUP && !flush_i) begin
      result_d = fix_res;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = early ? DONE : CALC;
      CALC:    if (count_q == 5'd31) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (flush_i && state_q != IDLE) state_d = IDLE;
  end

  always_comb begin
    ready_o  = (state_q == IDLE);
    busy_o   = (state_q != IDLE);
    done_o   = (state_q == DONE);
    result_o = result_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      count_q    <= 5'd0;
      acc_q      <= '0;
      opb_q      <= '0;
      op_q       <= 3'b000;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: one early-out instance and one full-iteration instance
// share operands; each has its own valid so only the targeted unit accepts.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        valid_a, valid_b;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        ready_a, busy_a, done_a;
  logic [31:0] result_a;
  logic        ready_b, busy_b, done_b;
  logic [31:0] result_b;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];

  muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_a), .op_i(op),
    .src_a_i(src_a), .src_b_i(src_b), .ready_o(ready_a), .busy_o(busy_a),
    .done_o(done_a), .result_o(result_a)
  );

  muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b0)) dut_noeo (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_b), .op_i(op),
    .src_a_i(src_a), .src_b_i(src_b), .ready_o(ready_b), .busy_o(busy_b),
    .done_o(done_b), .result_o(result_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called positioned just after a negedge; returns at a negedge.
  task automatic run_op(input bit use_b, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input string tag);
    bit seen;
    logic [31:0] got;
    check_eq({tag, "_ready_pre"}, 32'(use_b ? ready_b : ready_a), 32'd1);
    op = o; src_a = a; src_b = b;
    if (use_b) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0; valid_b = 1'b0;
    op = 3'($urandom_range(0, 7)); src_a = $urandom; src_b = $urandom;
    exp_q.push_back(exp);
    seen = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (use_b ? done_b : done_a) begin
        seen = 1'b1;
        got  = use_b ? result_b : result_a;
        check_eq({tag, "_latency"}, 32'(k), 32'(lat));
        check_eq({tag, "_result"}, got, exp_q.pop_front());
        break;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (!seen) void'(exp_q.pop_front());
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(use_b ? done_b : done_a), 32'd0);
    check_eq({tag, "_ready_post"}, 32'(use_b ? ready_b : ready_a), 32'd1);
    check_eq({tag, "_busy_post"}, 32'(use_b ? busy_b : busy_a), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    bit          leaked;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; flush = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    op = 3'b000; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_ready", 32'(ready_a), 32'd1);
    check_eq("reset_busy", 32'(busy_a), 32'd0);
    check_eq("reset_done", 32'(done_a), 32'd0);
    check_eq("reset_result", result_a, 32'd0);

    run_op(1'b0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul");
    run_op(1'b0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh");
    run_op(1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu");
    run_op(1'b0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu");
    run_op(1'b0, 3'b001, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 34, "mulh_neg");
    run_op(1'b0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div");
    run_op(1'b0, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem");
    run_op(1'b0, 3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 34, "divu");
    run_op(1'b0, 3'b111, 32'hFFFFFFF9, 32'd2,        32'h00000001, 34, "remu");
    run_op(1'b0, 3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34, "div_negb");
    run_op(1'b0, 3'b110, 32'd100,      32'hFFFFFFF9, 32'h00000002, 34, "rem_negb");
    run_op(1'b0, 3'b101, 32'h12345678, 32'd0,        32'hFFFFFFFF, 1,  "divu_by0_eo");
    run_op(1'b0, 3'b110, 32'h12345678, 32'd0,        32'h12345678, 1,  "rem_by0_eo");
    run_op(1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf_eo");
    run_op(1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf_eo");

    run_op(1'b1, 3'b101, 32'h12345678, 32'd0,        32'hFFFFFFFF, 34, "divu_by0_full");
    run_op(1'b1, 3'b110, 32'h12345678, 32'd0,        32'h12345678, 34, "rem_by0_full");
    run_op(1'b1, 3'b100, 32'h12345678, 32'd0,        32'hFFFFFFFF, 34, "div_by0_full");
    run_op(1'b1, 3'b111, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 34, "remu_by0_full");
    run_op(1'b1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, "div_ovf_full");
    run_op(1'b1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, "rem_ovf_full");

    // Flush a DIV at T+10, then a MUL accepted at T+11 must finish at T+45
    held = result_a;
    op = 3'b100; src_a = 32'd100; src_b = 32'd7; valid_a = 1'b1;
    @(posedge clk);
    #1 valid_a = 1'b0;
    leaked = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done_a) leaked = 1'b1;
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_no_done", 32'(leaked), 32'd0);
    check_eq("flush_ready", 32'(ready_a), 32'd1);
    check_eq("flush_result_held", result_a, held);
    run_op(1'b0, 3'b000, 32'd6, 32'd9, 32'd54, 34, "mul_after_flush");

    // Reset at T+20 of a multiply
    op = 3'b000; src_a = 32'd5; src_b = 32'd5; valid_a = 1'b1;
    @(posedge clk);
    #1 valid_a = 1'b0;
    leaked = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done_a) leaked = 1'b1;
      if (k == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_result", result_a, 32'd0);
    check_eq("rst_mid_ready", 32'(ready_a), 32'd1);
    check_eq("rst_mid_busy", 32'(busy_a), 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_a) leaked = 1'b1;
    end
    check_eq("rst_mid_no_done", 32'(leaked), 32'd0);

    // Flush together with valid in IDLE: nothing is accepted
    op = 3'b000; src_a = 32'd3; src_b = 32'd3; valid_a = 1'b1; flush = 1'b1;
    @(negedge clk);
    valid_a = 1'b0; flush = 1'b0;
    check_eq("flush_valid_busy", 32'(busy_a), 32'd0);
    check_eq("flush_valid_ready", 32'(ready_a), 32'd1);
    @(negedge clk);
    check_eq("flush_valid_no_done", 32'(done_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
